// File: rtl/ram_stream_reader.sv
// Read-side streaming engine for the dual-port RAM: walks (base, len), absorbs the
// one-cycle RAM read latency and presents the words on a valid/ready stream.
module ram_stream_reader #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [WIDTH-1:0]      ram_rdata_i,
    output logic [WIDTH-1:0]      m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        accept_cnt_q, accept_cnt_d;
    logic                    inflight_q, inflight_d;
    logic [WIDTH-1:0]        fifo_mem_q [2];
    logic [WIDTH-1:0]        fifo_mem_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;

    logic                    pop_c;
    logic                    push_c;
    logic                    rd_en_c;

    assign m_valid_o     = (fifo_cnt_q != 2'd0);
    assign m_data_o      = fifo_mem_q[rd_ptr_q];
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign ram_rd_addr_o = rd_addr_q;
    assign ram_rd_en_o   = rd_en_c;

    assign pop_c  = m_valid_o & m_ready_i;
    assign push_c = inflight_q;

    // Issue only while the FIFO plus the in-flight word leaves a free slot after this cycle's pop.
    assign rd_en_c = (state_q == S_RUN) &&
                     ((3'(fifo_cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_c)));

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        inflight_d   = rd_en_c;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = 2'(fifo_cnt_q + 2'(push_c) - 2'(pop_c));

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rd_addr_d    = base_addr_i;
                    issue_cnt_d  = len_i;
                    accept_cnt_d = len_i;
                    state_d      = (len_i == CNT_W'(0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en_c) begin
                    issue_cnt_d = issue_cnt_q - CNT_W'(1);
                    rd_addr_d   = ADDR_WIDTH'((int'(rd_addr_q) + 1) % int'(DEPTH));
                    if (issue_cnt_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
                if (pop_c) begin
                    accept_cnt_d = accept_cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (pop_c) begin
                    accept_cnt_d = accept_cnt_q - CNT_W'(1);
                    if (accept_cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_c) begin
            fifo_mem_d[wr_ptr_q] = ram_rdata_i;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // State and storage registers; reset flushes the FIFO and drops any in-flight word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            rd_addr_q     <= '0;
            issue_cnt_q   <= '0;
            accept_cnt_q  <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            issue_cnt_q   <= issue_cnt_d;
            accept_cnt_q  <= accept_cnt_d;
            inflight_q    <= inflight_d;
            fifo_mem_q    <= fifo_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, transfer-level reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_ram_stream_reader;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  base_addr_i;
    logic [8:0]  len_i;
    logic        busy_o;
    logic        done_o;
    logic        ram_rd_en_o;
    logic [7:0]  ram_rd_addr_o;
    logic [15:0] ram_rdata_i;
    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;

    ram_stream_reader dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .len_i         (len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ram_rd_en_o   (ram_rd_en_o),
        .ram_rd_addr_o (ram_rd_addr_o),
        .ram_rdata_i   (ram_rdata_i),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram [256];

    always @(posedge clk) begin
        if (ram_rd_en_o) ram_rdata_i <= ram[ram_rd_addr_o];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [7:0]  addr_log[$];
    logic [7:0]  exp_addr;
    int          issue_left;
    int          issued, accepted, landed;
    bit          busy_exp, done_exp;
    bit          stall_prev;
    logic [15:0] prev_data;
    int          done_pulses, beats, cyc, first_beat, last_beat;

    always @(negedge clk) begin : p_cmp
        bit pop, rd_exp, busy_nxt, done_nxt;
        int outst, issued_before;
        cyc++;
        if (rst_i) begin
            exp_q.delete();
            issue_left = 0; issued = 0; accepted = 0; landed = 0;
            busy_exp = 0; done_exp = 0; stall_prev = 0;
        end else begin
            pop           = m_valid_o & m_ready_i;
            outst         = issued - accepted;
            issued_before = issued;
            rd_exp        = busy_exp && !done_exp && (issue_left > 0) && (outst < 2 + int'(pop));

            chk("busy", busy_o, busy_exp);
            chk("done", done_o, done_exp);
            chk("valid", m_valid_o, landed > accepted);
            chk("rd_en", ram_rd_en_o, rd_exp);
            if (stall_prev) chk("stall_hold", m_data_o, prev_data);
            if (done_o) done_pulses++;

            busy_nxt = busy_exp;
            done_nxt = 0;
            if (done_exp) begin
                busy_nxt = 0;
            end else if (!busy_exp && start_i) begin
                exp_q.delete(); got_q.delete(); addr_log.delete();
                for (int i = 0; i < int'(len_i); i++) exp_q.push_back(ram[8'(int'(base_addr_i) + i)]);
                exp_addr   = base_addr_i;
                issue_left = int'(len_i);
                beats      = 0;
                busy_nxt   = 1;
                if (len_i == 9'd0) done_nxt = 1;
            end

            if (ram_rd_en_o) begin
                chk("rd_addr", ram_rd_addr_o, exp_addr);
                addr_log.push_back(ram_rd_addr_o);
                exp_addr = exp_addr + 8'd1;
                issue_left--;
                issued++;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", m_data_o, 16'hxxxx);
                end else begin
                    chk("data", m_data_o, exp_q.pop_front());
                end
                got_q.push_back(m_data_o);
                accepted++;
                if (beats == 0) first_beat = cyc;
                last_beat = cyc;
                beats++;
                if (exp_q.size() == 0 && issue_left <= 0) done_nxt = 1;
            end
            if (issued - accepted > 2) chk("outstanding_le2", 32'(issued - accepted), 32'd2);

            landed     = issued_before;
            stall_prev = m_valid_o & !m_ready_i;
            prev_data  = m_data_o;
            busy_exp   = busy_nxt;
            done_exp   = done_nxt;
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] l);
        base_addr_i = b;
        len_i       = l;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk({name, "_done_seen"}, seen, 1'b1);
        tick();
        chk({name, "_idle_after"}, busy_o, 1'b0);
    endtask

    task automatic chk_words(input string name, input logic [15:0] first, input int n);
        chk({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk({name, "_word"}, got_q[i], 16'(first + 16'(i)));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, busy_o, 1'b0);
        chk({name, "_done"}, done_o, 1'b0);
        chk({name, "_rd_en"}, ram_rd_en_o, 1'b0);
        chk({name, "_rd_addr"}, ram_rd_addr_o, 8'h00);
        chk({name, "_valid"}, m_valid_o, 1'b0);
        chk({name, "_data"}, m_data_o, 16'h0000);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit hit;
        for (int a = 0; a < 256; a++) ram[a] = 16'h1000 + 16'(a);
        ram_rdata_i = '0;
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b1;
        done_pulses = 0; beats = 0; cyc = 0;
        #3;
        chk_all_zero("reset");
        #20 rst_i = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // Basic 8-word burst at full rate
        done_pulses = 0;
        do_start(8'h00, 9'd8);
        wait_done("burst", 60);
        chk_words("burst", 16'h1000, 8);
        chk("burst_back_to_back", 32'(last_beat - first_beat), 32'd7);
        chk("burst_done_pulses", 32'(done_pulses), 32'd1);

        // Address wrap FE,FF,00,01
        do_start(8'hFE, 9'd4);
        wait_done("wrap", 40);
        chk("wrap_addr_n", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk("wrap_addr0", addr_log[0], 8'hFE);
            chk("wrap_addr1", addr_log[1], 8'hFF);
            chk("wrap_addr2", addr_log[2], 8'h00);
            chk("wrap_addr3", addr_log[3], 8'h01);
        end
        chk("wrap_n", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            chk("wrap_w0", got_q[0], 16'h10FE);
            chk("wrap_w1", got_q[1], 16'h10FF);
            chk("wrap_w2", got_q[2], 16'h1000);
            chk("wrap_w3", got_q[3], 16'h1001);
        end

        // Backpressure: ready low 6 cycles, then 1,0,1,0, then high
        m_ready_i = 1'b0;
        do_start(8'h10, 9'd8);
        repeat (5) tick();
        chk("bp_valid_stalled", m_valid_o, 1'b1);
        chk("bp_rd_en_blocked", ram_rd_en_o, 1'b0);
        m_ready_i = 1'b1; tick();
        m_ready_i = 1'b0; tick();
        m_ready_i = 1'b1; tick();
        m_ready_i = 1'b0; tick();
        m_ready_i = 1'b1;
        wait_done("bp", 60);
        chk_words("bp", 16'h1010, 8);

        // Zero-length transfer
        done_pulses = 0;
        do_start(8'h33, 9'd0);
        chk("zero_busy", busy_o, 1'b1);
        chk("zero_done", done_o, 1'b1);
        chk("zero_rd_en", ram_rd_en_o, 1'b0);
        tick();
        chk("zero_busy_after", busy_o, 1'b0);
        chk("zero_done_pulses", 32'(done_pulses), 32'd1);

        // Start during a transfer is ignored
        do_start(8'h40, 9'd6);
        tick(); tick();
        do_start(8'h80, 9'd5);
        wait_done("restart", 60);
        chk_words("restart", 16'h1040, 6);

        // Asynchronous reset after 3 beats, then a fresh short transfer
        do_start(8'h00, 9'd8);
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (beats >= 3) begin
                hit = 1;
                break;
            end
            tick();
        end
        chk("rst_three_beats", hit, 1'b1);
        #2 rst_i = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        #2 rst_i = 1'b0;
        tick();
        chk_all_zero("after_rst");
        do_start(8'h20, 9'd2);
        wait_done("post_rst", 40);
        chk_words("post_rst", 16'h1020, 2);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side engine for the dual-port RAM.
- On a start command it walks a block of addresses (base, length), drives the RAM read port, and absorbs the RAM's one-cycle read latency.
- It presents the read words as a valid/ready stream, so downstream consumers can apply backpressure without losing or duplicating words.
- It is the consumer counterpart to the RAM write side, running on the same clock.

Parameters:
- WIDTH, 16, data word width (matches RAM word width).
- ADDR_WIDTH, 8, RAM address width.
- DEPTH, 256, RAM depth; always equal to 2**ADDR_WIDTH.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  start command; sampled only in IDLE.
- base_addr_i  input  ADDR_WIDTH  first RAM address to read; captured with start_i.
- len_i  input  ADDR_WIDTH+1  number of words to read; captured with start_i.
- busy_o  output  1  high while state != IDLE.
- done_o  output  1  one-cycle pulse when the transfer completes.
- ram_rd_en_o  output  1  RAM read enable.
- ram_rd_addr_o  output  ADDR_WIDTH  RAM read address.
- ram_rdata_i  input  WIDTH  RAM read data; valid one cycle after ram_rd_en_o.
- m_data_o  output  WIDTH  stream data.
- m_valid_o  output  1  stream valid.
- m_ready_i  input  1  stream ready from consumer.

Behaviour:
- Clock/reset: one clock, clk_i. rst_i is asynchronous, active-high.
- Reset values: state IDLE, FIFO empty, in-flight flag 0, counters 0. busy_o=0, done_o=0, ram_rd_en_o=0, ram_rd_addr_o=0, m_valid_o=0, m_data_o=0.
- Reset mid-transfer: aborts immediately and flushes the FIFO. A RAM word returning in the cycle after reset deassertion is discarded.
- States:
  - IDLE -> RUN on start_i with len_i!=0 (capture base and len; issue counter = len, accept counter = len).
  - IDLE -> DONE on start_i with len_i==0.
  - RUN -> DRAIN when the last read issues.
  - DRAIN -> DONE when the last word is accepted (m_valid_o & m_ready_i).
  - DONE -> IDLE unconditionally.
- done_o is high exactly during the DONE cycle, i.e. the cycle after the final handshake.
- start_i is ignored outside IDLE.
- Storage: 2-entry output FIFO plus a 1-bit in-flight flag (a read was issued last cycle).
- Read issue:
  - ram_rd_en_o is combinational.
  - It asserts in RUN when (2 - fifo_count - inflight + pop) > 0, where pop = m_valid_o & m_ready_i.
  - This gives one word per cycle sustained when m_ready_i stays high.
  - It never causes FIFO overflow.
- Addressing:
  - ram_rd_addr_o = base + words_issued, modulo DEPTH; it wraps FF->00 for the default parameters.
  - len_i > DEPTH is legal and rereads wrapped addresses.
  - ram_rd_addr_o holds its last value when ram_rd_en_o=0.
- Data path:
  - ram_rdata_i is written into the FIFO on the edge following the cycle the in-flight flag is set.
  - m_data_o is the FIFO head; m_valid_o = fifo_count != 0.
  - While m_valid_o & !m_ready_i, m_data_o is held stable.
  - Simultaneous push and pop keeps the count unchanged.
- Latency: with m_ready_i=1 and start sampled at edge T, ram_rd_en_o is high during cycle T..T+1, and the first m_valid_o rises after edge T+2.
- Ordering: words come out in strict address order, with no loss or duplication.

Test Plan:
- Preload RAM[a]=16'h1000+a for a=0..7, start base=0 len=8, m_ready_i=1 -> m_data_o = 1000..1007 on 8 consecutive valid cycles; done_o pulses once, one cycle after the last beat; busy_o then falls.
- base=8'hFE, len=4 -> ram_rd_addr_o sequence FE, FF, 00, 01; stream carries RAM[FE], RAM[FF], RAM[00], RAM[01].
- len=8, m_ready_i held low for 6 cycles and then toggled 1,0,1,0 -> fifo_count never exceeds 2; ram_rd_en_o stays low while count+inflight=2 and no pop; m_data_o stable while stalled; all 8 words delivered in order.
- start with len=0 -> no ram_rd_en_o; busy_o high for one cycle; done_o pulses the next cycle.
- start_i asserted again mid-transfer with a different base -> ignored, original sequence completes.
- rst_i asserted asynchronously mid-transfer (after 3 beats) -> all outputs go to 0 immediately; a new start base=0x20 len=2 then delivers RAM[20], RAM[21] only.
